// File: rtl/shift_reg_sequencer_if.sv
// Command handshake bundle between an upstream controller and shift_reg_sequencer.
interface shift_reg_sequencer_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [WIDTH-1:0] cmd_data;
   logic [CNT_W-1:0] cmd_count;

   modport master (output cmd_valid, cmd_op, cmd_data, cmd_count, input cmd_ready);
   modport slave  (input cmd_valid, cmd_op, cmd_data, cmd_count, output cmd_ready);
endinterface

// File: rtl/shift_reg_sequencer.sv
// Expands LOAD/SHR/SHL/HOLD commands into per-cycle mode/fill/data for an 8-bit shift register.
// Optional macro SEQ_BACK2BACK_EN: accept the next command during the DONE cycle.
module shift_reg_sequencer #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   shift_reg_sequencer_if.slave cmd,
   output logic [1:0]       m_out,
   output logic             sl_out,
   output logic             sr_out,
   output logic [WIDTH-1:0] par_out,
   output logic             busy,
   output logic             done
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [1:0] OP_LOAD = 2'd0, OP_SHR = 2'd1, OP_SHL = 2'd2;
`ifdef SEQ_BACK2BACK_EN
   localparam bit B2B_EN = 1'b1;
`else
   localparam bit B2B_EN = 1'b0;
`endif

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [CW-1:0]    n_q, n_d;      // active cycles of the command in flight
   logic [CW-1:0]    cnt_q, cnt_d;  // index of the current active cycle
   logic             ready_q, ready_d, busy_q, busy_d, done_q, done_d;
   logic [1:0]       m_q, m_d;
   logic             sl_q, sl_d, sr_q, sr_d;
   logic [WIDTH-1:0] par_q, par_d;

   logic             accept, start, act_en;
   logic [1:0]       act_op;
   logic [WIDTH-1:0] act_data, shifted;
   logic [CW-1:0]    act_idx, eff, cnt_nxt;

   assign accept = cmd.cmd_valid && ready_q;

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      data_d   = data_q;
      n_d      = n_q;
      cnt_d    = cnt_q;
      ready_d  = ready_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      start    = 1'b0;
      act_en   = 1'b0;
      act_op   = op_q;
      act_data = data_q;
      act_idx  = cnt_q;
      eff      = (int'(cmd.cmd_count) > WIDTH) ? CW'(WIDTH) : CW'(cmd.cmd_count);
      cnt_nxt  = cnt_q + 1'b1;

      case (state_q)
         S_IDLE: begin
            busy_d  = 1'b0;
            ready_d = 1'b1;
            start   = accept;
         end
         S_RUN: begin
            // Compare with >= so the counter saturates instead of wrapping.
            if (cnt_nxt >= n_q) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               ready_d = B2B_EN;
            end else begin
               cnt_d   = cnt_nxt;
               act_en  = 1'b1;
               act_idx = cnt_nxt;
            end
         end
         S_DONE: begin
            if (B2B_EN && accept) begin
               start = 1'b1;
            end else begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               ready_d = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            ready_d = 1'b1;
         end
      endcase

      if (start) begin
         op_d   = cmd.cmd_op;
         data_d = cmd.cmd_data;
         n_d    = (cmd.cmd_op == OP_LOAD) ? CW'(1) : eff;
         cnt_d  = '0;
         busy_d = 1'b1;
         if (n_d == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            ready_d = B2B_EN;
         end else begin
            state_d  = S_RUN;
            ready_d  = 1'b0;
            act_en   = 1'b1;
            act_op   = cmd.cmd_op;
            act_data = cmd.cmd_data;
            act_idx  = '0;
         end
      end

      // Outputs are computed one cycle ahead so they appear registered.
      m_d     = 2'd0;
      sl_d    = 1'b0;
      sr_d    = 1'b0;
      par_d   = '0;
      shifted = act_data >> act_idx;
      if (act_en) begin
         case (act_op)
            OP_LOAD: begin m_d = 2'd3; par_d = act_data; end
            OP_SHR:  begin m_d = 2'd1; sl_d = shifted[0]; end
            OP_SHL:  begin m_d = 2'd2; sr_d = shifted[0]; end
            default: m_d = 2'd0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         data_q  <= '0;
         n_q     <= '0;
         cnt_q   <= '0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         m_q     <= '0;
         sl_q    <= 1'b0;
         sr_q    <= 1'b0;
         par_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         data_q  <= data_d;
         n_q     <= n_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         m_q     <= m_d;
         sl_q    <= sl_d;
         sr_q    <= sr_d;
         par_q   <= par_d;
      end
   end

   assign cmd.cmd_ready = ready_q;
   assign m_out   = m_q;
   assign sl_out  = sl_q;
   assign sr_out  = sr_q;
   assign par_out = par_q;
   assign busy    = busy_q;
   assign done    = done_q;
endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Scoreboard bench: a per-command reference model queues the expected per-cycle output stream.
module tb_shift_reg_sequencer;
   localparam int WIDTH = 8;
   localparam int CNT_W = 4;
`ifdef SEQ_BACK2BACK_EN
   localparam bit B2B = 1'b1;
`else
   localparam bit B2B = 1'b0;
`endif

   typedef struct packed {
      logic [1:0] m;
      logic       sl;
      logic       sr;
      logic [7:0] par;
      logic       done;
      logic       ready;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [1:0] m_out;
   logic sl_out, sr_out, busy, done;
   logic [WIDTH-1:0] par_out;
   logic [7:0] sreg = 8'h00;
   logic mon_en = 1'b0;
   int n_checks = 0;
   int n_fail = 0;
   exp_t exp_q[$];

   shift_reg_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   shift_reg_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .cmd(bus.slave),
      .m_out(m_out), .sl_out(sl_out), .sr_out(sr_out), .par_out(par_out),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference model: what the downstream register should see, cycle by cycle.
   function automatic void push_expect(input logic [1:0] op, input logic [7:0] d, input logic [3:0] c);
      int n;
      exp_t e;
      n = (op == 2'd0) ? 1 : ((int'(c) < 8) ? int'(c) : 8);
      for (int k = 0; k < n; k++) begin
         e = '0;
         case (op)
            2'd0: begin e.m = 2'd3; e.par = d; end
            2'd1: begin e.m = 2'd1; e.sl = d[k]; end
            2'd2: begin e.m = 2'd2; e.sr = d[k]; end
            default: e.m = 2'd0;
         endcase
         exp_q.push_back(e);
      end
      e = '0;
      e.done = 1'b1;
      e.ready = B2B;
      exp_q.push_back(e);
   endfunction

   // Downstream 8-bit register, samples on the falling edge.
   always @(negedge clk) begin
      case (m_out)
         2'd1: sreg <= {sl_out, sreg[7:1]};
         2'd2: sreg <= {sreg[6:0], sr_out};
         2'd3: sreg <= par_out;
         default: sreg <= sreg;
      endcase
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rst && mon_en) begin
         if (busy) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_busy", 32'(busy), 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("active_stream", 32'({m_out, sl_out, sr_out, par_out, done, bus.cmd_ready}), 32'(e));
            end
         end else begin
            chk("idle_outputs", 32'({m_out, sl_out, sr_out, par_out, done, bus.cmd_ready}), 32'({2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1}));
            chk("start_latency", 32'(exp_q.size()), 32'd0);
         end
      end
   end

   task automatic send(input logic [1:0] op, input logic [7:0] d, input logic [3:0] c);
      int w;
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_data  = d;
      bus.cmd_count = c;
      w = 0;
      while (!bus.cmd_ready && w < 60) begin
         @(negedge clk);
         w++;
      end
      if (!bus.cmd_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: cmd_ready stayed %b after %0d cycles", bus.cmd_ready, w);
         bus.cmd_valid = 1'b0;
         return;
      end
      @(posedge clk);
      push_expect(op, d, c);
      #1;
      bus.cmd_valid = 1'b0;
      // Scramble the inputs; the command in flight must not notice.
      bus.cmd_op    = 2'($urandom);
      bus.cmd_data  = 8'($urandom);
      bus.cmd_count = 4'($urandom);
   endtask

   task automatic wait_idle();
      int w;
      w = 0;
      do begin
         @(negedge clk);
         #1;
         w++;
      end while ((busy || exp_q.size() != 0) && w < 100);
      chk("drain", 32'({busy, exp_q.size() != 0}), 32'd0);
   endtask

   task automatic expect_sreg(input string name, input logic [7:0] v);
      chk(name, 32'(sreg), 32'(v));
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'd0;
      bus.cmd_data  = 8'h00;
      bus.cmd_count = 4'd0;
      #12;
      chk("reset_state", 32'({m_out, sl_out, sr_out, par_out, busy, done, bus.cmd_ready}),
          32'({2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1}));
      @(negedge clk);
      #2 rst = 1'b0;
      mon_en = 1'b1;

      send(2'd0, 8'hA5, 4'd0);
      wait_idle();
      expect_sreg("load_a5", 8'hA5);
      send(2'd1, 8'b0000_0101, 4'd3);
      wait_idle();
      expect_sreg("shr3_b4", 8'hB4);
      send(2'd2, 8'hFF, 4'd15);
      wait_idle();
      expect_sreg("shl_clamp_ff", 8'hFF);
      send(2'd3, 8'h5A, 4'd0);
      wait_idle();
      expect_sreg("hold0", 8'hFF);

      // Abort an 8-cycle SHL during its second active cycle.
      send(2'd2, 8'h00, 4'd8);
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_outputs", 32'({m_out, sl_out, sr_out, par_out, busy, done, bus.cmd_ready}),
          32'({2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1}));
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      send(2'd0, 8'h3C, 4'd5);
      wait_idle();
      expect_sreg("load_after_abort", 8'h3C);

      // Back-to-back pairs, including zero counts.
      send(2'd1, 8'h96, 4'd2);
      send(2'd2, 8'h0F, 4'd0);
      send(2'd3, 8'h00, 4'd2);
      send(2'd0, 8'hC3, 4'd9);
      wait_idle();
      expect_sreg("b2b_load", 8'hC3);

      for (int i = 0; i < 40; i++) begin
         send(2'($urandom), 8'($urandom), 4'($urandom_range(0, 15)));
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      wait_idle();
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
